// File: rtl/div_arb_pkg.sv
// div_arb_pkg
// Purpose: shared constants and types for the divider arbiter.
//   XLEN, BR_MASK_W, ROB_IDX_W, PDST_W, FCN_W : datapath field widths
//   MAX_SRC_W                                 : widest requester index (up to 4 requesters)
//   div_arb_state_e                           : arbiter FSM states
//   div_tag_t                                 : bookkeeping kept for the single in-flight op
package div_arb_pkg;

  localparam int XLEN      = 64;
  localparam int BR_MASK_W = 12;
  localparam int ROB_IDX_W = 6;
  localparam int PDST_W    = 7;
  localparam int FCN_W     = 4;
  localparam int MAX_SRC_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    KILL = 2'd2
  } div_arb_state_e;

  // The source index is stored at its widest size so the struct does not
  // depend on the requester count; the top narrows it on the way out.
  typedef struct packed {
    logic [MAX_SRC_W-1:0] src;
    logic [ROB_IDX_W-1:0] rob_idx;
    logic [PDST_W-1:0]    pdst;
    logic [BR_MASK_W-1:0] br_mask;
  } div_tag_t;

endpackage

// File: rtl/div_arbiter_rr_arbiter.sv
// rr_arbiter
// Purpose: combinational round-robin pick among eligible requesters,
// starting the search at the round-robin pointer and wrapping.
// Ports:
//   i_eligible  in  NUM_REQ  requesters allowed to win this cycle
//   i_rrPtr     in  SRC_W    highest-priority requester this cycle
//   o_grant     out NUM_REQ  one-hot grant (all zero when nobody eligible)
//   o_grantIdx  out SRC_W    index of the granted requester
//   o_anyGrant  out 1        at least one requester eligible
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int SRC_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_eligible,
  input  logic [SRC_W-1:0]   i_rrPtr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [SRC_W-1:0]   o_grantIdx,
  output logic               o_anyGrant
);

  // Walk the requesters in priority order from the pointer; the first
  // eligible one wins. The wrap is done in integer arithmetic so that
  // non-power-of-two requester counts behave.
  always_comb begin
    int             idxInt;
    logic [SRC_W-1:0] idx;
    logic           found;
    o_grant    = '0;
    o_grantIdx = '0;
    found      = 1'b0;
    idxInt     = 0;
    idx        = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idxInt = int'(i_rrPtr) + off;
      if (idxInt >= NUM_REQ) begin
        idxInt = idxInt - NUM_REQ;
      end
      idx = SRC_W'(idxInt);
      if (!found && i_eligible[idx]) begin
        found        = 1'b1;
        o_grant[idx] = 1'b1;
        o_grantIdx   = idx;
      end
    end
    o_anyGrant = found;
  end

endmodule

// File: rtl/div_arbiter.sv
// div_arbiter
// Purpose: shares one iterative divider (one op in flight) between NUM_REQ
// issue requesters with round-robin arbitration, tracks the in-flight uop
// tag and branch mask, kills the op on mispredict or flush, and returns the
// tagged result on a single response port. Request and response paths are
// combinational pass-throughs.
// Ports:
//   clock, reset (synchronous, active low)
//   req_*        per-requester issue interface (valid/ready, opcode, width,
//                branch mask, ROB index, pdst, operands), flattened vectors
//   brupdate_*   branch resolve / mispredict masks, flush kills everything
//   div_req_*    request to the divider, div_kill aborts the divider op
//   div_resp_*   divider result handshake
//   resp_*       tagged result to writeback
// Optional build macro DIV_ARBITER_PERF_EN adds saturating counters:
//   perf_busy_cycles[31:0], perf_kills[15:0], perf_grants[NUM_REQ*16-1:0]
module div_arbiter
  import div_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int SRC_W   = $clog2(NUM_REQ)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*FCN_W-1:0]     req_fcn,
  input  logic [NUM_REQ-1:0]           req_dw,
  input  logic [NUM_REQ*BR_MASK_W-1:0] req_br_mask,
  input  logic [NUM_REQ*ROB_IDX_W-1:0] req_rob_idx,
  input  logic [NUM_REQ*PDST_W-1:0]    req_pdst,
  input  logic [NUM_REQ*XLEN-1:0]      req_rs1,
  input  logic [NUM_REQ*XLEN-1:0]      req_rs2,
  input  logic [BR_MASK_W-1:0]         brupdate_resolve_mask,
  input  logic [BR_MASK_W-1:0]         brupdate_mispredict_mask,
  input  logic                         flush,
  output logic                         div_req_valid,
  input  logic                         div_req_ready,
  output logic [FCN_W-1:0]             div_req_fn,
  output logic                         div_req_dw,
  output logic [XLEN-1:0]              div_req_in1,
  output logic [XLEN-1:0]              div_req_in2,
  output logic                         div_kill,
  input  logic                         div_resp_valid,
  input  logic [XLEN-1:0]              div_resp_data,
  output logic                         div_resp_ready,
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic [SRC_W-1:0]             resp_src,
  output logic [ROB_IDX_W-1:0]         resp_rob_idx,
  output logic [PDST_W-1:0]            resp_pdst,
  output logic [XLEN-1:0]              resp_data
`ifdef DIV_ARBITER_PERF_EN
  ,
  output logic [31:0]                  perf_busy_cycles,
  output logic [15:0]                  perf_kills,
  output logic [NUM_REQ*16-1:0]        perf_grants
`endif
);

  div_arb_state_e         r_state;
  div_arb_state_e         w_nextState;
  div_tag_t               r_tag;
  logic [SRC_W-1:0]       r_rrPtr;

  logic [NUM_REQ-1:0]     w_eligible;
  logic [NUM_REQ-1:0]     w_grant;
  logic [SRC_W-1:0]       w_grantIdx;
  logic                   w_anyGrant;
  logic [ROB_IDX_W-1:0]   w_grantRob;
  logic [PDST_W-1:0]      w_grantPdst;
  logic [BR_MASK_W-1:0]   w_grantBrMask;
  logic                   w_issueFire;
  logic                   w_killNow;

  // A requester whose uop sits under a branch mispredicted this very cycle
  // is already dead, so it must not be allowed to win.
  always_comb begin
    w_eligible = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_eligible[i] = req_valid[i]
                    && ((req_br_mask[i*BR_MASK_W +: BR_MASK_W] & brupdate_mispredict_mask) == '0)
                    && !flush;
    end
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .SRC_W   (SRC_W)
  ) u_rrArbiter (
    .i_eligible (w_eligible),
    .i_rrPtr    (r_rrPtr),
    .o_grant    (w_grant),
    .o_grantIdx (w_grantIdx),
    .o_anyGrant (w_anyGrant)
  );

  // Operand and tag mux driven by the one-hot grant.
  always_comb begin
    div_req_fn    = '0;
    div_req_dw    = 1'b0;
    div_req_in1   = '0;
    div_req_in2   = '0;
    w_grantRob    = '0;
    w_grantPdst   = '0;
    w_grantBrMask = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        div_req_fn    = req_fcn[i*FCN_W +: FCN_W];
        div_req_dw    = req_dw[i];
        div_req_in1   = req_rs1[i*XLEN +: XLEN];
        div_req_in2   = req_rs2[i*XLEN +: XLEN];
        w_grantRob    = req_rob_idx[i*ROB_IDX_W +: ROB_IDX_W];
        w_grantPdst   = req_pdst[i*PDST_W +: PDST_W];
        w_grantBrMask = req_br_mask[i*BR_MASK_W +: BR_MASK_W];
      end
    end
  end

  assign w_issueFire = div_req_valid && div_req_ready;
  // Evaluated on the stored mask, before this cycle's resolve clears bits.
  assign w_killNow   = flush || ((r_tag.br_mask & brupdate_mispredict_mask) != '0);

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (w_issueFire) begin
          w_nextState = BUSY;
        end
      end
      BUSY: begin
        if (w_killNow) begin
          w_nextState = KILL;
        end else if (div_resp_valid && resp_ready) begin
          w_nextState = IDLE;
        end
      end
      KILL: begin
        if (div_req_ready) begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Handshake outputs. Reset holds div_kill high so a divider op that was
  // in flight when reset arrived is aborted rather than left dangling.
  // A kill in BUSY suppresses any result the divider presents that cycle.
  always_comb begin
    req_ready      = '0;
    div_req_valid  = 1'b0;
    div_kill       = 1'b0;
    div_resp_ready = 1'b0;
    resp_valid     = 1'b0;
    if (!reset) begin
      div_kill = 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          div_req_valid = w_anyGrant;
          req_ready     = w_grant & {NUM_REQ{div_req_ready}};
        end
        BUSY: begin
          if (w_killNow) begin
            div_kill = 1'b1;
          end else begin
            resp_valid     = div_resp_valid;
            div_resp_ready = resp_ready;
          end
        end
        KILL: begin
          div_resp_ready = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Tag capture at issue; while the op is in flight its branch mask keeps
  // shedding resolved branches so a later mispredict on a resolved branch
  // does not kill it.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_tag   <= '0;
      r_rrPtr <= '0;
    end else if (w_issueFire) begin
      r_tag.src     <= MAX_SRC_W'(w_grantIdx);
      r_tag.rob_idx <= w_grantRob;
      r_tag.pdst    <= w_grantPdst;
      r_tag.br_mask <= w_grantBrMask & ~brupdate_resolve_mask;
      r_rrPtr       <= (w_grantIdx == SRC_W'(NUM_REQ - 1)) ? '0 : w_grantIdx + SRC_W'(1);
    end else if (r_state == BUSY) begin
      r_tag.br_mask <= r_tag.br_mask & ~brupdate_resolve_mask;
    end
  end

  assign resp_src     = SRC_W'(r_tag.src);
  assign resp_rob_idx = r_tag.rob_idx;
  assign resp_pdst    = r_tag.pdst;
  assign resp_data    = div_resp_data;

`ifdef DIV_ARBITER_PERF_EN
  logic [31:0]           r_perfBusy;
  logic [15:0]           r_perfKills;
  logic [NUM_REQ*16-1:0] r_perfGrants;

  // All counters stick at their maximum instead of wrapping.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_perfBusy   <= '0;
      r_perfKills  <= '0;
      r_perfGrants <= '0;
    end else begin
      if ((r_state == BUSY) && (r_perfBusy != '1)) begin
        r_perfBusy <= r_perfBusy + 32'd1;
      end
      if ((r_state == BUSY) && w_killNow && (r_perfKills != '1)) begin
        r_perfKills <= r_perfKills + 16'd1;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_issueFire && w_grant[i] && (r_perfGrants[i*16 +: 16] != 16'hFFFF)) begin
          r_perfGrants[i*16 +: 16] <= r_perfGrants[i*16 +: 16] + 16'd1;
        end
      end
    end
  end

  assign perf_busy_cycles = r_perfBusy;
  assign perf_kills       = r_perfKills;
  assign perf_grants      = r_perfGrants;
`endif

endmodule

// File: tb/tb_div_arbiter.sv
// tb_div_arbiter
// Purpose: self-checking bench for div_arbiter with two requesters, a
// simple multi-cycle divider responder, a transaction-level reference model
// checked every cycle, and directed scenarios with literal expectations.
module tb_div_arbiter;

  localparam int N  = 2;
  localparam int SW = $clog2(N);

  logic              clock = 1'b1;
  logic              reset;
  logic [N-1:0]      reqValid;
  logic [N-1:0]      reqReady;
  logic [N*4-1:0]    reqFcn;
  logic [N-1:0]      reqDw;
  logic [N*12-1:0]   reqBrMask;
  logic [N*6-1:0]    reqRobIdx;
  logic [N*7-1:0]    reqPdst;
  logic [N*64-1:0]   reqRs1;
  logic [N*64-1:0]   reqRs2;
  logic [11:0]       resolveMask;
  logic [11:0]       mispMask;
  logic              flush;
  logic              divReqValid;
  logic              divReqReady;
  logic [3:0]        divReqFn;
  logic              divReqDw;
  logic [63:0]       divReqIn1;
  logic [63:0]       divReqIn2;
  logic              divKill;
  logic              divRespValid;
  logic [63:0]       divRespData;
  logic              divRespReady;
  logic              respValid;
  logic              respReady;
  logic [SW-1:0]     respSrc;
  logic [5:0]        respRobIdx;
  logic [6:0]        respPdst;
  logic [63:0]       respData;

  int testsRun;
  int testsFailed;

  always #5 clock = ~clock;

  div_arbiter #(.NUM_REQ(N)) dut (
    .clock                    (clock),
    .reset                    (reset),
    .req_valid                (reqValid),
    .req_ready                (reqReady),
    .req_fcn                  (reqFcn),
    .req_dw                   (reqDw),
    .req_br_mask              (reqBrMask),
    .req_rob_idx              (reqRobIdx),
    .req_pdst                 (reqPdst),
    .req_rs1                  (reqRs1),
    .req_rs2                  (reqRs2),
    .brupdate_resolve_mask    (resolveMask),
    .brupdate_mispredict_mask (mispMask),
    .flush                    (flush),
    .div_req_valid            (divReqValid),
    .div_req_ready            (divReqReady),
    .div_req_fn               (divReqFn),
    .div_req_dw               (divReqDw),
    .div_req_in1              (divReqIn1),
    .div_req_in2              (divReqIn2),
    .div_kill                 (divKill),
    .div_resp_valid           (divRespValid),
    .div_resp_data            (divRespData),
    .div_resp_ready           (divRespReady),
    .resp_valid               (respValid),
    .resp_ready               (respReady),
    .resp_src                 (respSrc),
    .resp_rob_idx             (respRobIdx),
    .resp_pdst                (respPdst),
    .resp_data                (respData)
  );

  function automatic logic [63:0] quot(input logic [63:0] a, input logic [63:0] b, input logic dw);
    logic [31:0] a32;
    logic [31:0] b32;
    a32 = a[31:0];
    b32 = b[31:0];
    if (dw) return (b == 64'd0) ? 64'hFFFF_FFFF_FFFF_FFFF : a / b;
    return {32'd0, (b32 == 32'd0) ? 32'hFFFF_FFFF : a32 / b32};
  endfunction

  // Stand-in divider: accepts when idle, answers four cycles later, holds
  // the result until taken, and drops everything on kill or reset.
  logic       dBusy;
  logic [2:0] dCnt;
  assign divReqReady = !dBusy;

  always @(posedge clock) begin
    if (!reset || divKill) begin
      dBusy        <= 1'b0;
      divRespValid <= 1'b0;
      dCnt         <= 3'd0;
    end else if (!dBusy) begin
      if (divReqValid) begin
        dBusy       <= 1'b1;
        dCnt        <= 3'd3;
        divRespData <= quot(divReqIn1, divReqIn2, divReqDw);
      end
    end else if (!divRespValid) begin
      if (dCnt == 3'd0) divRespValid <= 1'b1;
      else dCnt <= dCnt - 3'd1;
    end else if (divRespReady) begin
      divRespValid <= 1'b0;
      dBusy        <= 1'b0;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: phase 0 = no op outstanding, 1 = op with the divider,
  // 2 = op killed and waiting for the divider to go idle.
  int          mPhase = 0;
  int          mPtr = 0;
  int          mSrc = 0;
  logic [5:0]  mRob = '0;
  logic [6:0]  mPdst = '0;
  logic [11:0] mMask = '0;
  logic [63:0] mQuot = '0;

  int          respCount = 0;
  int          killCount = 0;
  int          logSrc [16];
  logic [63:0] logData [16];
  logic [5:0]  logRob [16];
  logic [6:0]  logPdst [16];

  task automatic modelCompare();
    logic [N-1:0] elig;
    logic [N-1:0] expReady;
    int           g;
    int           idx;
    bit           any;
    bit           kill;
    elig = '0;
    for (int i = 0; i < N; i++) begin
      elig[i] = reqValid[i] && ((reqBrMask[i*12 +: 12] & mispMask) == 12'h0) && !flush;
    end
    any = 1'b0;
    g   = 0;
    for (int off = 0; off < N; off++) begin
      idx = (mPtr + off) % N;
      if (!any && elig[idx]) begin
        any = 1'b1;
        g   = idx;
      end
    end
    if (!reset) begin
      checkOutput("rst_div_kill", divKill, 1);
      checkOutput("rst_div_req_valid", divReqValid, 0);
      checkOutput("rst_req_ready", reqReady, 0);
      checkOutput("rst_resp_valid", respValid, 0);
      checkOutput("rst_div_resp_ready", divRespReady, 0);
      mPhase = 0;
      mPtr   = 0;
    end else if (mPhase == 0) begin
      expReady = '0;
      if (any && divReqReady) expReady[g] = 1'b1;
      checkOutput("idle_div_req_valid", divReqValid, any);
      checkOutput("idle_req_ready", reqReady, expReady);
      checkOutput("idle_div_kill", divKill, 0);
      checkOutput("idle_resp_valid", respValid, 0);
      if (any) begin
        checkOutput("idle_fn", divReqFn, reqFcn[g*4 +: 4]);
        checkOutput("idle_dw", divReqDw, reqDw[g]);
        checkOutput("idle_in1", divReqIn1, reqRs1[g*64 +: 64]);
        checkOutput("idle_in2", divReqIn2, reqRs2[g*64 +: 64]);
      end
      if (any && divReqReady) begin
        mPhase = 1;
        mSrc   = g;
        mRob   = reqRobIdx[g*6 +: 6];
        mPdst  = reqPdst[g*7 +: 7];
        mMask  = reqBrMask[g*12 +: 12] & ~resolveMask;
        mQuot  = quot(reqRs1[g*64 +: 64], reqRs2[g*64 +: 64], reqDw[g]);
        mPtr   = (g + 1) % N;
      end
    end else if (mPhase == 1) begin
      kill = flush || ((mMask & mispMask) != 12'h0);
      checkOutput("busy_div_req_valid", divReqValid, 0);
      checkOutput("busy_req_ready", reqReady, 0);
      checkOutput("busy_div_kill", divKill, kill);
      checkOutput("busy_resp_valid", respValid, !kill && divRespValid);
      if (!kill) checkOutput("busy_div_resp_ready", divRespReady, respReady);
      if (!kill && divRespValid) begin
        checkOutput("resp_src", respSrc, mSrc);
        checkOutput("resp_rob_idx", respRobIdx, mRob);
        checkOutput("resp_pdst", respPdst, mPdst);
        checkOutput("resp_data", respData, mQuot);
      end
      if (kill) mPhase = 2;
      else if (divRespValid && respReady) mPhase = 0;
      mMask = mMask & ~resolveMask;
    end else begin
      checkOutput("kill_req_ready", reqReady, 0);
      checkOutput("kill_div_req_valid", divReqValid, 0);
      checkOutput("kill_div_resp_ready", divRespReady, 1);
      checkOutput("kill_resp_valid", respValid, 0);
      checkOutput("kill_div_kill", divKill, 0);
      if (divReqReady) mPhase = 0;
    end
    if (reset && respValid && respReady) begin
      if (respCount < 16) begin
        logSrc[respCount]  = int'(respSrc);
        logData[respCount] = respData;
        logRob[respCount]  = respRobIdx;
        logPdst[respCount] = respPdst;
      end
      respCount++;
    end
    if (reset && divKill) killCount++;
  endtask

  // Per-cycle compare, sampled 3 time units after the negedge where inputs
  // change and 2 units before the active edge.
  initial begin
    forever begin
      @(negedge clock);
      #3;
      modelCompare();
    end
  end

  task automatic applyStimulus(input int idx, input logic [3:0] fcn, input logic dw,
                               input logic [11:0] br, input logic [5:0] rob, input logic [6:0] pdst,
                               input logic [63:0] rs1, input logic [63:0] rs2);
    reqValid[idx]            = 1'b1;
    reqFcn[idx*4 +: 4]       = fcn;
    reqDw[idx]               = dw;
    reqBrMask[idx*12 +: 12]  = br;
    reqRobIdx[idx*6 +: 6]    = rob;
    reqPdst[idx*7 +: 7]      = pdst;
    reqRs1[idx*64 +: 64]     = rs1;
    reqRs2[idx*64 +: 64]     = rs2;
  endtask

  // One cycle; requesters drop valid after being accepted.
  task automatic tick(output logic [N-1:0] acc);
    #3;
    acc = reqValid & reqReady;
    @(negedge clock);
    reqValid = reqValid & ~acc;
  endtask

  task automatic waitResp(input int target, input int budget);
    logic [N-1:0] acc;
    int n;
    n = 0;
    while (respCount < target && n < budget) begin
      tick(acc);
      n++;
    end
    checkOutput("resp_wait", respCount >= target, 1);
  endtask

  task automatic waitAccept(input int idx, input int budget);
    logic [N-1:0] acc;
    int n;
    n = 0;
    while (reqValid[idx] && n < budget) begin
      tick(acc);
      n++;
    end
    checkOutput("accept_wait", reqValid[idx], 0);
  endtask

  initial begin
    logic [N-1:0] acc;
    int rc;
    int kc;
    int n;
    testsRun    = 0;
    testsFailed = 0;
    reset       = 1'b0;
    reqValid    = '0;
    reqFcn      = '0;
    reqDw       = '0;
    reqBrMask   = '0;
    reqRobIdx   = '0;
    reqPdst     = '0;
    reqRs1      = '0;
    reqRs2      = '0;
    resolveMask = '0;
    mispMask    = '0;
    flush       = 1'b0;
    respReady   = 1'b1;

    @(negedge clock);
    tick(acc);
    tick(acc);
    #3;
    checkOutput("lit_reset_div_kill", divKill, 1);
    checkOutput("lit_reset_req_ready", reqReady, 0);
    checkOutput("lit_reset_resp_valid", respValid, 0);
    @(negedge clock);
    reset = 1'b1;

    // Both requesters at once from rr_ptr 0: 0 first, then 1.
    applyStimulus(0, 4'h4, 1'b1, 12'h000, 6'd5, 7'd33, 64'd100, 64'd7);
    applyStimulus(1, 4'h5, 1'b1, 12'h000, 6'd9, 7'd40, 64'd200, 64'd10);
    tick(acc);
    checkOutput("lit_t1_first_grant", acc, 2'b01);
    waitResp(2, 60);
    checkOutput("lit_t1_src0", logSrc[0], 0);
    checkOutput("lit_t1_data0", logData[0], 64'd14);
    checkOutput("lit_t1_rob0", logRob[0], 6'd5);
    checkOutput("lit_t1_pdst0", logPdst[0], 7'd33);
    checkOutput("lit_t1_src1", logSrc[1], 1);
    checkOutput("lit_t1_data1", logData[1], 64'd20);
    checkOutput("lit_t1_rob1", logRob[1], 6'd9);
    repeat (3) tick(acc);
    checkOutput("lit_t1_resp_count", respCount, 2);

    // Mispredict on the in-flight op's branch.
    rc = respCount;
    kc = killCount;
    applyStimulus(0, 4'h4, 1'b1, 12'h004, 6'd11, 7'd12, 64'd50, 64'd5);
    waitAccept(0, 20);
    mispMask = 12'h004;
    #3;
    checkOutput("lit_t3_div_kill", divKill, 1);
    checkOutput("lit_t3_resp_valid", respValid, 0);
    @(negedge clock);
    mispMask = 12'h000;
    repeat (4) tick(acc);
    checkOutput("lit_t3_kill_pulses", killCount - kc, 1);
    checkOutput("lit_t3_no_resp", respCount - rc, 0);
    applyStimulus(1, 4'h5, 1'b1, 12'h000, 6'd13, 7'd14, 64'd30, 64'd3);
    waitResp(rc + 1, 40);
    checkOutput("lit_t3_next_src", logSrc[rc], 1);
    checkOutput("lit_t3_next_data", logData[rc], 64'd10);

    // Branch resolved, then mispredicted two cycles later: no kill.
    rc = respCount;
    kc = killCount;
    respReady = 1'b0;
    applyStimulus(0, 4'h4, 1'b1, 12'h004, 6'd21, 7'd22, 64'd60, 64'd6);
    waitAccept(0, 20);
    resolveMask = 12'h004;
    tick(acc);
    resolveMask = 12'h000;
    tick(acc);
    mispMask = 12'h004;
    tick(acc);
    mispMask = 12'h000;
    respReady = 1'b1;
    waitResp(rc + 1, 40);
    checkOutput("lit_t4_no_kill", killCount - kc, 0);
    checkOutput("lit_t4_src", logSrc[rc], 0);
    checkOutput("lit_t4_data", logData[rc], 64'd10);
    checkOutput("lit_t4_rob", logRob[rc], 6'd21);

    // Result held under back-pressure, then flushed.
    rc = respCount;
    kc = killCount;
    respReady = 1'b0;
    applyStimulus(1, 4'h5, 1'b1, 12'h000, 6'd31, 7'd32, 64'd77, 64'd7);
    waitAccept(1, 20);
    n = 0;
    while (!divRespValid && n < 20) begin
      tick(acc);
      n++;
    end
    checkOutput("lit_t5_div_resp_seen", divRespValid, 1);
    applyStimulus(0, 4'h4, 1'b1, 12'h000, 6'd41, 7'd42, 64'd90, 64'd9);
    repeat (5) begin
      tick(acc);
      checkOutput("lit_t5_held_no_accept", acc, 0);
    end
    flush = 1'b1;
    tick(acc);
    checkOutput("lit_t5_flush_no_accept", acc, 0);
    flush = 1'b0;
    respReady = 1'b1;
    tick(acc);
    checkOutput("lit_t5_kill_state_no_accept", acc, 0);
    waitResp(rc + 1, 40);
    checkOutput("lit_t5_kill_pulses", killCount - kc, 1);
    checkOutput("lit_t5_src", logSrc[rc], 0);
    checkOutput("lit_t5_data", logData[rc], 64'd10);
    repeat (3) tick(acc);
    checkOutput("lit_t5_one_resp", respCount - rc, 1);

    // Squashed requester at the pointer is skipped for the other one.
    rc = respCount;
    repeat (2) tick(acc);
    applyStimulus(1, 4'h5, 1'b1, 12'h010, 6'd50, 7'd51, 64'd40, 64'd4);
    applyStimulus(0, 4'h4, 1'b1, 12'h000, 6'd52, 7'd53, 64'd81, 64'd9);
    mispMask = 12'h010;
    tick(acc);
    checkOutput("lit_t6_grant", acc, 2'b01);
    mispMask = 12'h000;
    reqValid[1] = 1'b0;
    waitResp(rc + 1, 40);
    checkOutput("lit_t6_src", logSrc[rc], 0);
    checkOutput("lit_t6_data", logData[rc], 64'd9);

    // Reset while an op is in flight.
    rc = respCount;
    applyStimulus(0, 4'h4, 1'b1, 12'h000, 6'd61, 7'd62, 64'd70, 64'd7);
    waitAccept(0, 20);
    reset = 1'b0;
    #3;
    checkOutput("lit_t7_reset_kill", divKill, 1);
    checkOutput("lit_t7_reset_resp_valid", respValid, 0);
    @(negedge clock);
    tick(acc);
    reset = 1'b1;
    repeat (8) tick(acc);
    checkOutput("lit_t7_no_resp", respCount - rc, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

endmodule
